// File: rtl/recursive_logic_pipe.sv
// Two-stage valid/ready bitwise logic unit (2**S bits) with an accumulate mode.
// The datapath is assembled from recursively split gate and reduction trees.

// Recursive 2-input bitwise gate. FN selects the function: 0 buf(a), 1 not(a),
// 2 and, 3 or, 4 xor, 5 xnor, 6 nand, 7 nor.
module recursive_gate #(
  parameter int S  = 0,
  parameter int FN = 0
) (
  input  logic [(1<<S)-1:0] a,
  input  logic [(1<<S)-1:0] b,
  output logic [(1<<S)-1:0] y
);
  // One 4-entry truth table per function, indexed by {a, b}.
  localparam logic [31:0] TRUTH = 32'b0001_0111_1001_0110_1110_1000_0011_1100;
  localparam logic [3:0]  TT    = TRUTH[4*FN +: 4];

  generate
    if (S == 0) begin : g_leaf
      assign y[0] = TT[{a[0], b[0]}];
    end else begin : g_split
      localparam int H = 1 << (S - 1);
      recursive_gate #(.S(S - 1), .FN(FN)) u_lo (
        .a (a[H-1:0]),
        .b (b[H-1:0]),
        .y (y[H-1:0])
      );
      recursive_gate #(.S(S - 1), .FN(FN)) u_hi (
        .a (a[2*H-1:H]),
        .b (b[2*H-1:H]),
        .y (y[2*H-1:H])
      );
    end
  endgenerate
endmodule

// Recursive reduction tree: FN 0 reduces with and, FN 1 reduces with or.
module recursive_reduce #(
  parameter int S  = 0,
  parameter int FN = 0
) (
  input  logic [(1<<S)-1:0] a,
  output logic              y
);
  generate
    if (S == 0) begin : g_leaf
      assign y = a[0];
    end else begin : g_split
      localparam int H = 1 << (S - 1);
      logic y_lo;
      logic y_hi;
      recursive_reduce #(.S(S - 1), .FN(FN)) u_lo (
        .a (a[H-1:0]),
        .y (y_lo)
      );
      recursive_reduce #(.S(S - 1), .FN(FN)) u_hi (
        .a (a[2*H-1:H]),
        .y (y_hi)
      );
      if (FN == 1) begin : g_or
        assign y = y_lo | y_hi;
      end else begin : g_and
        assign y = y_lo & y_hi;
      end
    end
  endgenerate
endmodule

module recursive_logic_pipe #(
  parameter int S = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic                acc,
  input  logic                acc_init,
  input  logic [(1<<S)-1:0]   in1,
  input  logic [(1<<S)-1:0]   in2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [(1<<S)-1:0]   out,
  output logic                out_zero,
  output logic                out_ones
);
  localparam int W = 1 << S;

  // Stage 1: raw operand capture
  logic         s1_valid_reg;
  logic [W-1:0] s1_in1_reg;
  logic [W-1:0] s1_in2_reg;
  logic [2:0]   s1_op_reg;
  logic         s1_acc_reg;
  logic         s1_init_reg;

  // Stage 2: output register and accumulator
  logic         out_valid_reg;
  logic [W-1:0] out_reg;
  logic         out_zero_reg;
  logic         out_ones_reg;
  logic [W-1:0] acc_reg;

  logic         s2_adv;
  logic         in_fire;
  logic [W-1:0] b_operand;
  logic [W-1:0] fn_y [8];
  logic [W-1:0] result_next;
  logic         any_one_next;
  logic         all_ones_next;
  logic         writes_acc;

  assign s2_adv   = s1_valid_reg && (!out_valid_reg || out_ready);
  // Combinational ready path: a draining output frees stage 1 in the same cycle.
  assign in_ready = !rst && (!s1_valid_reg || s2_adv);
  assign in_fire  = in_valid && in_ready;

  // The accumulator is read in stage 2, so a chained acc item always sees
  // the value written by the item directly ahead of it.
  assign b_operand = s1_acc_reg ? acc_reg : s1_in2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_fn
      recursive_gate #(.S(S), .FN(gi)) u_gate (
        .a (s1_in1_reg),
        .b (b_operand),
        .y (fn_y[gi])
      );
    end
  endgenerate

  assign result_next = s1_init_reg ? s1_in1_reg : fn_y[s1_op_reg];
  assign writes_acc  = s1_init_reg || s1_acc_reg;

  recursive_reduce #(.S(S), .FN(1)) u_any_one (
    .a (result_next),
    .y (any_one_next)
  );

  recursive_reduce #(.S(S), .FN(0)) u_all_ones (
    .a (result_next),
    .y (all_ones_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_in1_reg    <= '0;
      s1_in2_reg    <= '0;
      s1_op_reg     <= 3'd0;
      s1_acc_reg    <= 1'b0;
      s1_init_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      out_zero_reg  <= 1'b1;
      out_ones_reg  <= 1'b0;
      acc_reg       <= '0;
    end else begin
      if (in_fire) begin
        s1_valid_reg <= 1'b1;
        s1_in1_reg   <= in1;
        s1_in2_reg   <= in2;
        s1_op_reg    <= op;
        s1_acc_reg   <= acc;
        s1_init_reg  <= acc_init;
      end else if (s2_adv) begin
        s1_valid_reg <= 1'b0;
      end

      if (s2_adv) begin
        out_valid_reg <= 1'b1;
        out_reg       <= result_next;
        out_zero_reg  <= !any_one_next;
        out_ones_reg  <= all_ones_next;
        if (writes_acc) begin
          acc_reg <= result_next;
        end
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign out_zero  = out_zero_reg;
  assign out_ones  = out_ones_reg;
endmodule
